// File: rtl/spi_master_param.sv
// Run-time configurable SPI master: per-transaction size, chip select,
// clock divider and CPOL/CPHA, with val/rdy host handshakes.
module spi_master_param #(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_CS    = 4,
    parameter int DIV_W     = 8,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int SIZE_W   = $clog2(BIT_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 packet_size_val,
    output logic                 packet_size_rdy,
    input  logic [SIZE_W-1:0]    packet_size_msg,
    input  logic                 cs_addr_val,
    output logic                 cs_addr_rdy,
    input  logic [CS_W-1:0]      cs_addr_msg,
    input  logic                 cfg_val,
    output logic                 cfg_rdy,
    input  logic [DIV_W+1:0]     cfg_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic [NUM_CS-1:0]    cs,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int EW = SIZE_W + 1;
    localparam logic [SIZE_W-1:0] FULL = SIZE_W'(BIT_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_e;

    state_e                state_q, state_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [CS_W-1:0]       addr_q, addr_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BIT_WIDTH-1:0]  tx_q, tx_d;
    logic [BIT_WIDTH-1:0]  rx_q, rx_d;
    logic [NUM_CS-1:0]     cs_q, cs_d;
    logic                  sclk_q, sclk_d;

    logic          idle;
    logic          tick;
    logic          lead;
    logic [EW-1:0] edge_inc;
    logic          last;

    function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] s);
        if (s == '0 || s > FULL) begin
            return FULL;
        end
        return s;
    endfunction

    assign idle     = (state_q == IDLE);
    assign tick     = (cnt_q == '0);
    assign lead     = ~edge_q[0];
    assign edge_inc = edge_q + EW'(1);
    assign last     = (edge_inc == {eff_size(size_q), 1'b0});

    assign recv_rdy        = idle;
    assign packet_size_rdy = idle;
    assign cs_addr_rdy     = idle;
    assign cfg_rdy         = idle;
    assign send_val        = (state_q == DONE);
    assign send_msg        = send_val ? rx_q : '0;
    assign cs              = cs_q;
    assign sclk            = sclk_q;
    assign mosi            = (state_q == SETUP || state_q == XFER || state_q == HOLD)
                             ? tx_q[BIT_WIDTH-1] : 1'b0;

    always_comb begin
        state_d = state_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        div_d   = div_q;
        size_d  = size_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;

        if (idle && cfg_val) {cpol_d, cpha_d, div_d} = cfg_msg;
        if (idle && packet_size_val) size_d = packet_size_msg;
        if (idle && cs_addr_val) addr_d = cs_addr_msg;

        if (state_q == SETUP || state_q == XFER || state_q == HOLD) begin
            cnt_d = tick ? div_q : cnt_q - DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                // sclk parks at the (possibly just written) polarity
                sclk_d = cpol_d;
                if (recv_val) begin
                    state_d = SETUP;
                    cnt_d   = div_d;
                    edge_d  = '0;
                    rx_d    = '0;
                    tx_d    = recv_msg << (FULL - eff_size(size_d));
                    for (int i = 0; i < NUM_CS; i++) begin
                        cs_d[i] = (int'(addr_d) != i);
                    end
                end
            end
            SETUP: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_inc;
                    if (lead != cpha_q) begin
                        rx_d = {rx_q[BIT_WIDTH-2:0], miso};
                    end
                    // cpha=1 already presents bit 0 from SETUP
                    if (lead == cpha_q && !(cpha_q && edge_q == '0)) begin
                        tx_d = tx_q << 1;
                    end
                    if (last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                    cs_d    = '1;
                end
            end
            DONE: begin
                if (send_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            div_q   <= '0;
            size_q  <= FULL;
            addr_q  <= '0;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cs_q    <= '1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            div_q   <= div_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
        end
    end

endmodule
